// File: rtl/output_driver_sequencer_if.sv
// Request and CSR-write bundle between the configuration/pattern
// requesters and the output-driver sequencer.
interface output_driver_sequencer_if #(
  parameter int CHANNEL_COUNT         = 8,
  parameter int CHANNEL_SEL_WIDTH     = 3,
  parameter int SERDES_WIDTH          = 4,
  parameter int COARSE_DELAY_WIDTH    = 22,
  parameter int COARSE_WIDTH_WIDTH    = 20,
  parameter int PATTERN_ADDRESS_WIDTH = 13
);
  localparam int DIW = COARSE_DELAY_WIDTH + SERDES_WIDTH;
  localparam int WIW = COARSE_WIDTH_WIDTH + SERDES_WIDTH;

  logic                             cfgValid;
  logic                             cfgReady;
  logic [CHANNEL_SEL_WIDTH-1:0]     cfgChannel;
  logic                             cfgTimingEnable;
  logic [1:0]                       cfgMode;
  logic [DIW-1:0]                   cfgDelayInfo;
  logic [WIW-1:0]                   cfgWidthInfo;

  logic                             patValid;
  logic                             patReady;
  logic [CHANNEL_SEL_WIDTH-1:0]     patChannel;
  logic [PATTERN_ADDRESS_WIDTH-1:0] patAddress;
  logic [SERDES_WIDTH-1:0]          patData;

  logic [CHANNEL_COUNT-1:0]         sysCsrStrobe;
  logic [31:0]                      sysGPIO_OUT;
  logic                             busy;
  logic                             channelError;

  modport master (
    output cfgValid, cfgChannel, cfgTimingEnable,
    output cfgMode, cfgDelayInfo, cfgWidthInfo,
    output patValid, patChannel, patAddress, patData,
    input  cfgReady, patReady,
    input  sysCsrStrobe, sysGPIO_OUT, busy, channelError
  );

  modport slave (
    input  cfgValid, cfgChannel, cfgTimingEnable,
    input  cfgMode, cfgDelayInfo, cfgWidthInfo,
    input  patValid, patChannel, patAddress, patData,
    output cfgReady, patReady,
    output sysCsrStrobe, sysGPIO_OUT, busy, channelError
  );
endinterface

// File: rtl/output_driver_sequencer.sv
// Arbitrates config/pattern requests and serialises them into
// delay/width/mode/pattern CSR words for a bank of output drivers.
module output_driver_sequencer #(
  parameter int CHANNEL_COUNT         = 8,
  parameter int CHANNEL_SEL_WIDTH     = 3,
  parameter int SERDES_WIDTH          = 4,
  parameter int COARSE_DELAY_WIDTH    = 22,
  parameter int COARSE_WIDTH_WIDTH    = 20,
  parameter int PATTERN_ADDRESS_WIDTH = 13,
  parameter int SETTLE_CYCLES         = 8
) (
  input logic sysClk,
  input logic sysReset,
  output_driver_sequencer_if.slave bus
);
  localparam int CC  = CHANNEL_COUNT;
  localparam int CSW = CHANNEL_SEL_WIDTH;
  localparam int DIW = COARSE_DELAY_WIDTH + SERDES_WIDTH;
  localparam int WIW = COARSE_WIDTH_WIDTH + SERDES_WIDTH;
  localparam int PAW = PATTERN_ADDRESS_WIDTH;
  localparam int CW  = (SETTLE_CYCLES > 0) ?
                       $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_WIDTH,
    S_MODE,
    S_PATTERN,
    S_SETTLE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_lastPat;
  logic [CSW-1:0]   r_chan;
  logic [1:0]       r_mode;
  logic [WIW-1:0]   r_width;
  logic [CW-1:0]    r_cnt;
  logic [CC-1:0]    r_strb;
  logic [CC-1:0]    w_strb;
  logic [31:0]      r_gpio;
  logic [31:0]      w_gpio;
  logic             r_err;
  logic             w_err;
  logic             w_idle;
  logic             w_cfgRdy;
  logic             w_patRdy;
  logic             w_cfgAcc;
  logic             w_patAcc;

  // Out-of-range channels decode to an all-zero strobe.
  function automatic logic [CC-1:0] f_onehot(input logic [CSW-1:0] ch);
    logic [CC-1:0] oh;
    for (int i = 0; i < CC; i++) oh[i] = (32'(ch) == i);
    return oh;
  endfunction

  function automatic logic f_oor(input logic [CSW-1:0] ch);
    return 32'(ch) >= CC;
  endfunction

  function automatic logic [31:0] f_mode(input logic [1:0] m);
    logic [31:0] x;
    x = '0;
    x[1:0] = m;
    return x;
  endfunction

  function automatic logic [31:0] f_delay(input logic [DIW-1:0] d);
    logic [31:0] x;
    x = '0;
    x[31:30] = 2'd1;
    x[DIW-1:0] = d;
    return x;
  endfunction

  function automatic logic [31:0] f_width(input logic [WIW-1:0] w);
    logic [31:0] x;
    x = '0;
    x[31:30] = 2'd2;
    x[WIW-1:0] = w;
    return x;
  endfunction

  function automatic logic [31:0] f_pat(
    input logic [PAW-1:0]          a,
    input logic [SERDES_WIDTH-1:0] d
  );
    logic [31:0] x;
    x = '0;
    x[31:30] = 2'd3;
    x[10 +: PAW] = a;
    x[0 +: SERDES_WIDTH] = d;
    return x;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_cfgRdy = w_idle && (!bus.patValid || r_lastPat);
  assign w_patRdy = w_idle && (!bus.cfgValid || !r_lastPat);
  assign w_cfgAcc = bus.cfgValid && w_cfgRdy;
  assign w_patAcc = bus.patValid && w_patRdy;

  // Outputs are computed for the next state so the registered
  // strobe/word line up exactly with the word states.
  always_comb begin
    w_next = r_state;
    w_strb = '0;
    w_gpio = '0;
    w_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cfgAcc) begin
          w_err  = f_oor(bus.cfgChannel);
          w_strb = f_onehot(bus.cfgChannel);
          if (bus.cfgTimingEnable) begin
            w_next = S_DELAY;
            w_gpio = f_delay(bus.cfgDelayInfo);
          end else begin
            w_next = S_MODE;
            w_gpio = f_mode(bus.cfgMode);
          end
        end else if (w_patAcc) begin
          w_next = S_PATTERN;
          w_err  = f_oor(bus.patChannel);
          w_strb = f_onehot(bus.patChannel);
          w_gpio = f_pat(bus.patAddress, bus.patData);
        end
      end
      S_DELAY: begin
        w_next = S_WIDTH;
        w_strb = f_onehot(r_chan);
        w_gpio = f_width(r_width);
      end
      S_WIDTH: begin
        w_next = S_MODE;
        w_strb = f_onehot(r_chan);
        w_gpio = f_mode(r_mode);
      end
      S_MODE: begin
        w_next = (SETTLE_CYCLES > 0) ? S_SETTLE : S_IDLE;
      end
      S_PATTERN: begin
        w_next = S_IDLE;
      end
      S_SETTLE: begin
        if (r_cnt == CW'(1)) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      r_state   <= S_IDLE;
      r_strb    <= '0;
      r_gpio    <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_lastPat <= 1'b1;
      r_chan    <= '0;
      r_mode    <= '0;
      r_width   <= '0;
    end else begin
      r_state <= w_next;
      r_strb  <= w_strb;
      r_gpio  <= w_gpio;
      r_err   <= w_err;
      if (w_cfgAcc) begin
        r_lastPat <= 1'b0;
        r_chan    <= bus.cfgChannel;
        r_mode    <= bus.cfgMode;
        r_width   <= bus.cfgWidthInfo;
      end else if (w_patAcc) begin
        r_lastPat <= 1'b1;
      end
      if (r_state == S_MODE) r_cnt <= CW'(SETTLE_CYCLES);
      else if (r_state == S_SETTLE) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign bus.cfgReady     = w_cfgRdy;
  assign bus.patReady     = w_patRdy;
  assign bus.sysCsrStrobe = r_strb;
  assign bus.sysGPIO_OUT  = r_gpio;
  assign bus.busy         = !w_idle;
  assign bus.channelError = r_err;
endmodule

// File: tb/tb_output_driver_sequencer.sv
// Bench for output_driver_sequencer: directed scenarios plus
// randomized two-requester traffic against a transaction-level model.
module tb_output_driver_sequencer;
  localparam int CC     = 8;
  localparam int CSW    = 4;
  localparam int SW     = 4;
  localparam int CDW    = 22;
  localparam int CWW    = 20;
  localparam int PAW    = 13;
  localparam int SETTLE = 8;

  typedef struct {
    logic [CSW-1:0] ch;
    bit             t;
    logic [1:0]     m;
    logic [25:0]    d;
    logic [23:0]    w;
  } cfg_t;

  typedef struct {
    logic [CSW-1:0] ch;
    logic [12:0]    a;
    logic [3:0]     d;
  } pat_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  output_driver_sequencer_if #(
    .CHANNEL_COUNT(CC), .CHANNEL_SEL_WIDTH(CSW),
    .SERDES_WIDTH(SW), .COARSE_DELAY_WIDTH(CDW),
    .COARSE_WIDTH_WIDTH(CWW), .PATTERN_ADDRESS_WIDTH(PAW)
  ) bus ();

  output_driver_sequencer #(
    .CHANNEL_COUNT(CC), .CHANNEL_SEL_WIDTH(CSW),
    .SERDES_WIDTH(SW), .COARSE_DELAY_WIDTH(CDW),
    .COARSE_WIDTH_WIDTH(CWW), .PATTERN_ADDRESS_WIDTH(PAW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .sysClk(clk),
    .sysReset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w_delay(input logic [25:0] d);
    return 32'h4000_0000 | 32'(d);
  endfunction

  function automatic logic [31:0] w_width(input logic [23:0] w);
    return 32'h8000_0000 | 32'(w);
  endfunction

  function automatic logic [31:0] w_pat(input logic [12:0] a,
                                        input logic [3:0] d);
    return 32'hC000_0000 | (32'(a) << 10) | 32'(d);
  endfunction

  task automatic idle_in();
    bus.cfgValid = 0;
    bus.cfgChannel = '0;
    bus.cfgTimingEnable = 0;
    bus.cfgMode = '0;
    bus.cfgDelayInfo = '0;
    bus.cfgWidthInfo = '0;
    bus.patValid = 0;
    bus.patChannel = '0;
    bus.patAddress = '0;
    bus.patData = '0;
  endtask

  task automatic drive_cfg(input cfg_t c, input bit v);
    bus.cfgValid = v;
    bus.cfgChannel = c.ch;
    bus.cfgTimingEnable = c.t;
    bus.cfgMode = c.m;
    bus.cfgDelayInfo = c.d;
    bus.cfgWidthInfo = c.w;
  endtask

  task automatic drive_pat(input pat_t q, input bit v);
    bus.patValid = v;
    bus.patChannel = q.ch;
    bus.patAddress = q.a;
    bus.patData = q.d;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.sysCsrStrobe !== '0 || bus.sysGPIO_OUT !== '0) begin
      n_fail++;
      $display("FAIL rst_out: strb %h gpio %h want 0 0",
               bus.sysCsrStrobe, bus.sysGPIO_OUT);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.channelError !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: busy %b err %b want 0 0",
               bus.busy, bus.channelError);
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (bus.cfgReady !== 1'b1 || bus.patReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: cfgR %b patR %b want 1 1",
               bus.cfgReady, bus.patReady);
    end
    bus.cfgValid = 1;
    bus.patValid = 1;
    #1;
    n_cmp++;
    if (bus.cfgReady !== 1'b1 || bus.patReady !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tie: cfgR %b patR %b want 1 0",
               bus.cfgReady, bus.patReady);
    end
    idle_in();
  endtask

  task automatic test_config();
    logic [31:0] ew;
    logic [7:0]  es;
    @(negedge clk);
    bus.cfgValid = 1;
    bus.cfgChannel = 4'd2;
    bus.cfgTimingEnable = 1;
    bus.cfgMode = 2'd1;
    bus.cfgDelayInfo = 26'h000_0015;
    bus.cfgWidthInfo = 24'h00_0003;
    #1;
    n_cmp++;
    if (bus.cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_accept: cfgReady %b want 1", bus.cfgReady);
    end
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) idle_in();
      case (k)
        1: ew = 32'h4000_0015;
        2: ew = 32'h8000_0003;
        3: ew = 32'h0000_0001;
        default: ew = 32'h0;
      endcase
      es = (k <= 3) ? 8'h04 : 8'h00;
      n_cmp++;
      if (bus.sysCsrStrobe !== es || bus.sysGPIO_OUT !== ew) begin
        n_fail++;
        $display("FAIL cfg_word k=%0d: strb %h gpio %h want %h %h",
                 k, bus.sysCsrStrobe, bus.sysGPIO_OUT, es, ew);
      end
      n_cmp++;
      if (bus.cfgReady !== (k >= 12) || bus.busy !== (k < 12)) begin
        n_fail++;
        $display("FAIL cfg_ready k=%0d: rdy %b busy %b want %b %b",
                 k, bus.cfgReady, bus.busy, k >= 12, k < 12);
      end
    end
  endtask

  task automatic test_pattern();
    @(negedge clk);
    bus.patValid = 1;
    bus.patChannel = 4'd5;
    bus.patAddress = 13'h1ABC;
    bus.patData = 4'hA;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    n_cmp++;
    if (bus.sysCsrStrobe !== 8'h20 ||
        bus.sysGPIO_OUT !== 32'hC06A_F00A) begin
      n_fail++;
      $display("FAIL pat_word: strb %h gpio %h want 20 c06af00a",
               bus.sysCsrStrobe, bus.sysGPIO_OUT);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.sysCsrStrobe !== '0 || bus.patReady !== 1'b1) begin
      n_fail++;
      $display("FAIL pat_done: strb %h patR %b want 0 1",
               bus.sysCsrStrobe, bus.patReady);
    end
  endtask

  task automatic test_back_to_back();
    pat_t q[4];
    logic [7:0] es;
    for (int j = 0; j < 4; j++) begin
      q[j].ch = CSW'($urandom_range(0, CC - 1));
      q[j].a  = 13'($urandom);
      q[j].d  = 4'($urandom);
    end
    @(negedge clk);
    drive_pat(q[0], 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      es = 8'(1) << q[j].ch;
      n_cmp++;
      if (bus.sysCsrStrobe !== es ||
          bus.sysGPIO_OUT !== w_pat(q[j].a, q[j].d)) begin
        n_fail++;
        $display("FAIL b2b_word j=%0d: strb %h gpio %h want %h %h",
                 j, bus.sysCsrStrobe, bus.sysGPIO_OUT, es,
                 w_pat(q[j].a, q[j].d));
      end
      if (j < 3) drive_pat(q[j+1], 1);
      else idle_in();
      @(negedge clk);
      n_cmp++;
      if (bus.sysCsrStrobe !== '0 || bus.patReady !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gap j=%0d: strb %h patR %b want 0 1",
                 j, bus.sysCsrStrobe, bus.patReady);
      end
    end
  endtask

  task automatic test_channel_error();
    logic [25:0] d;
    logic [23:0] w;
    logic [31:0] ew;
    d = 26'($urandom);
    w = 24'($urandom);
    @(negedge clk);
    bus.cfgValid = 1;
    bus.cfgChannel = 4'd9;
    bus.cfgTimingEnable = 1;
    bus.cfgMode = 2'd3;
    bus.cfgDelayInfo = d;
    bus.cfgWidthInfo = w;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) idle_in();
      case (k)
        1: ew = w_delay(d);
        2: ew = w_width(w);
        3: ew = 32'h0000_0003;
        default: ew = 32'h0;
      endcase
      n_cmp++;
      if (bus.sysCsrStrobe !== '0 || bus.sysGPIO_OUT !== ew ||
          bus.channelError !== (k == 1)) begin
        n_fail++;
        $display("FAIL err_cfg k=%0d: strb %h gpio %h err %b want 0 %h %b",
                 k, bus.sysCsrStrobe, bus.sysGPIO_OUT,
                 bus.channelError, ew, k == 1);
      end
      n_cmp++;
      if (bus.cfgReady !== (k >= 12)) begin
        n_fail++;
        $display("FAIL err_ready k=%0d: rdy %b want %b",
                 k, bus.cfgReady, k >= 12);
      end
    end
    bus.patValid = 1;
    bus.patChannel = 4'd12;
    bus.patAddress = 13'h0155;
    bus.patData = 4'h3;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    n_cmp++;
    if (bus.sysCsrStrobe !== '0 || bus.channelError !== 1'b1) begin
      n_fail++;
      $display("FAIL err_pat: strb %h err %b want 0 1",
               bus.sysCsrStrobe, bus.channelError);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.patReady !== 1'b1 || bus.channelError !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pat_done: patR %b err %b want 1 0",
               bus.patReady, bus.channelError);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cfgValid = 1;
    bus.cfgChannel = 4'd3;
    bus.cfgTimingEnable = 1;
    bus.cfgMode = 2'd2;
    bus.cfgDelayInfo = 26'h123_4567;
    bus.cfgWidthInfo = 24'h89_ABCD;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    n_cmp++;
    if (bus.sysCsrStrobe !== '0 || bus.sysGPIO_OUT !== '0 ||
        bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear: strb %h gpio %h busy %b want 0 0 0",
               bus.sysCsrStrobe, bus.sysGPIO_OUT, bus.busy);
    end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.sysCsrStrobe !== '0 || bus.sysGPIO_OUT !== '0) begin
        n_fail++;
        $display("FAIL rmid_nomode k=%0d: strb %h gpio %h want 0 0",
                 k, bus.sysCsrStrobe, bus.sysGPIO_OUT);
      end
    end
    bus.cfgValid = 1;
    bus.cfgChannel = 4'd6;
    bus.cfgTimingEnable = 0;
    bus.cfgMode = 2'd2;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) idle_in();
      n_cmp++;
      if (bus.sysCsrStrobe !== ((k == 1) ? 8'h40 : 8'h00) ||
          bus.sysGPIO_OUT !== ((k == 1) ? 32'h2 : 32'h0) ||
          bus.cfgReady !== (k >= 10)) begin
        n_fail++;
        $display("FAIL rmid_new k=%0d: strb %h gpio %h rdy %b",
                 k, bus.sysCsrStrobe, bus.sysGPIO_OUT, bus.cfgReady);
      end
    end
  endtask

  // Transaction-level model: tracks when the sequencer is free and
  // which requester was last granted, and books expected words.
  task automatic test_random();
    cfg_t cq[$];
    pat_t pq[$];
    cfg_t c;
    pat_t q;
    logic [CC-1:0] e_strb[int];
    logic [31:0]   e_gpio[int];
    bit            e_err[int];
    logic [31:0]   words[3];
    logic [CC-1:0] xs;
    logic [31:0]   xw;
    bit xe, cv, pv, ecr, epr, acc_c, acc_p, last_pat;
    int gc, gp, p, free_at, n;
    for (int i = 0; i < 12; i++) begin
      c.ch = CSW'($urandom_range(0, 9));
      c.t  = 1'($urandom_range(0, 1));
      c.m  = 2'($urandom);
      c.d  = 26'($urandom);
      c.w  = 24'($urandom);
      cq.push_back(c);
    end
    for (int i = 0; i < 30; i++) begin
      q.ch = CSW'($urandom_range(0, 9));
      q.a  = 13'($urandom);
      q.d  = 4'($urandom);
      pq.push_back(q);
    end
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    gc = 0;
    gp = 0;
    p = 0;
    free_at = 0;
    last_pat = 1;
    drive_cfg(cq[0], 1);
    drive_pat(pq[0], 1);
    #1;
    while (p < 3000 &&
           (cq.size() > 0 || pq.size() > 0 || p < free_at + 2)) begin
      xs = e_strb.exists(p) ? e_strb[p] : '0;
      xw = e_gpio.exists(p) ? e_gpio[p] : '0;
      xe = e_err.exists(p) ? e_err[p] : 1'b0;
      n_cmp++;
      if (bus.sysCsrStrobe !== xs || bus.sysGPIO_OUT !== xw) begin
        n_fail++;
        $display("FAIL rnd_word p=%0d: strb %h gpio %h want %h %h",
                 p, bus.sysCsrStrobe, bus.sysGPIO_OUT, xs, xw);
      end
      n_cmp++;
      if (bus.channelError !== xe || bus.busy !== (p < free_at)) begin
        n_fail++;
        $display("FAIL rnd_flags p=%0d: err %b busy %b want %b %b",
                 p, bus.channelError, bus.busy, xe, p < free_at);
      end
      cv = cq.size() > 0 && gc == 0;
      pv = pq.size() > 0 && gp == 0;
      ecr = (p >= free_at) && (!pv || last_pat);
      epr = (p >= free_at) && (!cv || !last_pat);
      n_cmp++;
      if (bus.cfgReady !== ecr || bus.patReady !== epr) begin
        n_fail++;
        $display("FAIL rnd_ready p=%0d: cfgR %b patR %b want %b %b",
                 p, bus.cfgReady, bus.patReady, ecr, epr);
      end
      acc_c = cv && ecr;
      acc_p = pv && epr;
      if (acc_c) begin
        c = cq[0];
        n = c.t ? 3 : 1;
        words[0] = c.t ? w_delay(c.d) : 32'(c.m);
        words[1] = w_width(c.w);
        words[2] = 32'(c.m);
        for (int i = 0; i < n; i++) begin
          e_strb[p+1+i] = (int'(c.ch) < CC) ? (CC'(1) << c.ch) : '0;
          e_gpio[p+1+i] = words[i];
        end
        e_err[p+1] = int'(c.ch) >= CC;
        free_at = p + 1 + n + SETTLE;
        last_pat = 0;
      end else if (acc_p) begin
        q = pq[0];
        e_strb[p+1] = (int'(q.ch) < CC) ? (CC'(1) << q.ch) : '0;
        e_gpio[p+1] = w_pat(q.a, q.d);
        e_err[p+1] = int'(q.ch) >= CC;
        free_at = p + 2;
        last_pat = 1;
      end
      @(posedge clk);
      #1;
      p++;
      if (gc > 0) gc--;
      if (gp > 0) gp--;
      if (acc_c) begin
        void'(cq.pop_front());
        gc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      end
      if (acc_p) begin
        void'(pq.pop_front());
        gp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      end
      if (cq.size() > 0) drive_cfg(cq[0], gc == 0);
      else bus.cfgValid = 0;
      if (pq.size() > 0) drive_pat(pq[0], gp == 0);
      else bus.patValid = 0;
      @(negedge clk);
    end
    n_cmp++;
    if (p >= 3000) begin
      n_fail++;
      $display("FAIL rnd_timeout: cfg left %0d pat left %0d want 0 0",
               cq.size(), pq.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0;
    rst = 1;
    n_cmp = 0;
    n_fail = 0;
    idle_in();
    test_reset();
    test_config();
    test_pattern();
    test_back_to_back();
    test_channel_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/output_driver_sequencer.md
# output_driver_sequencer

Sequencer and arbiter for the CSR write port of a bank of output drivers, in the system clock domain. It accepts whole-pulse configuration requests and single pattern-RAM writes from two requesters. It serialises each configuration request into the driver's delay, width and mode CSR words, always in that order. It then holds off further configuration for a settle interval, so the driver's EVR-domain toggle handshake has latched the new parameters before they can be overwritten.

## Interface
- `CHANNEL_COUNT`, 8: number of output drivers served.
- `CHANNEL_SEL_WIDTH`, 3: width of channel select fields.
- `SERDES_WIDTH`, 4: driver SERDES width.
- `COARSE_DELAY_WIDTH`, 22: driver coarse-delay width. Delay info width is `COARSE_DELAY_WIDTH+SERDES_WIDTH`, 26.
- `COARSE_WIDTH_WIDTH`, 20: driver coarse-width width. Width info width is `COARSE_WIDTH_WIDTH+SERDES_WIDTH`, 24.
- `PATTERN_ADDRESS_WIDTH`, 13: driver pattern RAM address width.
- `SETTLE_CYCLES`, 8: hold-off cycles after each mode write. 0 means no hold-off.

Ports:
- `sysClk`, in, 1: clock.
- `sysReset`, in, 1: asynchronous, active-high reset.
- `cfgValid`, in, 1: configuration requester handshake.
- `cfgReady`, out, 1: configuration requester handshake.
- `cfgChannel`, in, CHANNEL_SEL_WIDTH: target driver.
- `cfgTimingEnable`, in, 1: 1 writes delay, width and mode; 0 writes mode only.
- `cfgMode`, in, 2: driver mode. 0 disabled, 1 pulse, 2 pattern single, 3 pattern loop.
- `cfgDelayInfo`, in, 26: {coarse delay, first pattern}.
- `cfgWidthInfo`, in, 24: {coarse width, last pattern}.
- `patValid`, in, 1: pattern requester handshake.
- `patReady`, out, 1: pattern requester handshake.
- `patChannel`, in, CHANNEL_SEL_WIDTH: target driver.
- `patAddress`, in, PATTERN_ADDRESS_WIDTH: pattern RAM address.
- `patData`, in, SERDES_WIDTH: pattern RAM data.
- `sysCsrStrobe`, out, CHANNEL_COUNT: one-hot per-driver write strobe, registered.
- `sysGPIO_OUT`, out, 32: shared CSR write word, registered.
- `busy`, out, 1: high in any state other than IDLE.
- `channelError`, out, 1: one-cycle pulse when an accepted request targets a channel ≥ CHANNEL_COUNT.

## Operation
- CSR word formats. Bits [31:30] are the opcode. All unused bits are 0.
  - Mode word: {2'd0, 0…, mode[1:0]}.
  - Delay word: {2'd1, 0…, delayInfo[25:0]}.
  - Width word: {2'd2, 0…, widthInfo[23:0]}.
  - Pattern word: {2'd3, 0…, address at [22:10], 0…, data at [3:0]}.
- States:
  - IDLE.
  - DELAY, WIDTH and MODE: each issues one word.
  - PATTERN: issues one word.
  - SETTLE: counts SETTLE_CYCLES.
- Ready signals are combinational from state and the `lastGrant` register:
  - `cfgReady = IDLE && (!patValid || lastGrant==PAT)`.
  - `patReady = IDLE && (!cfgValid || lastGrant==CFG)`.
  - With one requester pending, it wins. With both pending, they alternate.
  - `lastGrant` updates on every acceptance.
- Configuration acceptance: latch all cfg fields. Go to DELAY if `cfgTimingEnable`, else MODE. DELAY goes to WIDTH, WIDTH to MODE. MODE goes to SETTLE if SETTLE_CYCLES>0, else IDLE. SETTLE goes to IDLE when its count expires.
- Pattern acceptance: latch fields, go to PATTERN, then IDLE.
- The sequence for an accepted request is uninterruptible. No request is accepted outside IDLE, including during SETTLE.
- Each word state asserts exactly one strobe bit, `sysCsrStrobe[channel]`, for one cycle, with the matching `sysGPIO_OUT`.
- Outside word states: `sysCsrStrobe`=0 and `sysGPIO_OUT`=0.
- Out-of-range channel:
  - The full sequence, including SETTLE, still runs with identical timing.
  - `sysCsrStrobe` stays 0 throughout.
  - `channelError` pulses in the cycle after acceptance.
- Reset, asynchronous:
  - State → IDLE. `sysCsrStrobe`, `sysGPIO_OUT`, `busy`, `channelError` → 0. Settle counter → 0. `lastGrant` → PAT, so configuration wins the first tie.
  - Reset mid-sequence abandons the remaining words. Delay/width words already written without a mode word are harmless: the driver adopts them only on the next mode write.

## Timing
- Handshake at edge N with `cfgTimingEnable`=1: delay strobe in cycle N+1, width in N+2, mode in N+3. SETTLE covers N+4 … N+3+SETTLE_CYCLES. `cfgReady` can rise in cycle N+4+SETTLE_CYCLES.
- With `cfgTimingEnable`=0: mode strobe in N+1. Ready can rise in N+2+SETTLE_CYCLES.
- Pattern accepted at N: strobe in N+1, ready can rise in N+2. Peak throughput is one pattern word per 2 cycles.
- Settle counter width is clog2(SETTLE_CYCLES+1). It is loaded to SETTLE_CYCLES when leaving MODE and decremented each cycle. SETTLE exits on the cycle it reads 1.
- Requesters must hold request fields stable only until the accepting edge.

## Test plan
- Config: ch 2, timing=1, mode 1, delay 26'h000_0015, width 24'h00_0003, SETTLE_CYCLES=8 → three single-cycle strobes on bit 2 only:
  - N+1: 32'h4000_0015.
  - N+2: 32'h8000_0003.
  - N+3: 32'h0000_0001.
  - `cfgReady` low through N+11.
- Pattern: ch 5, addr 13'h1ABC, data 4'hA → N+1: strobe bit 5, word 32'hC06A_F00A.
- Back-to-back pattern writes with `patValid` held → strobes every 2nd cycle, addresses in order, no gaps beyond 1 cycle.
- Both requesters valid continuously → grants alternate, configuration first after reset. No pattern strobe appears between a request's delay and mode words or during SETTLE.
- Channel 9 with CHANNEL_COUNT=8 → `channelError` pulse at N+1, no strobe bits ever set, ready timing identical to a valid channel.
- `sysReset` asserted in the cycle of the width strobe → strobes and GPIO 0 immediately, no mode word issued. After release, a new request is accepted from IDLE with normal timing.
